mul_div_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, beside the ALU; takes the same DataA/DataB operands.
- Executes MULT/MULTU/DIV/DIVU in WIDTH+1 cycles. Executes MTHI/MTLO in a single cycle.
- Holds the architectural HI/LO registers, which feed the ALU result mux for MFHI/MFLO.
- Raises busy so the control/hazard logic can stall MFHI/MFLO and any new mul/div.

---
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is a right-shifting shift-add on operand magnitudes; divide is a
// restoring divide on magnitudes. Signs are applied in a final fix-up cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      count_q;
  logic               vld_p2;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Latched operation context; data only, no reset needed.
  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   b_mag_p1;
  logic [WIDTH-1:0]   a_raw_p1;
  logic               is_div_p1;
  logic               neg_q_p1;
  logic               neg_r_p1;
  logic               div0_p1;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic               op_signed;
  logic               accept_md;
  logic               accept_mthi;
  logic               accept_mtlo;
  logic               fix_commit;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Magnitude of an operand; unsigned ops pass straight through.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic use_sign);
    if (use_sign && v[WIDTH-1]) return ~v + WIDTH'(1);
    else return v;
  endfunction

  // Conditional two's-complement negation of a single-width result.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic neg);
    if (neg) return ~v + WIDTH'(1);
    else return v;
  endfunction

  // Conditional two's-complement negation of the double-width product.
  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    if (neg) return ~v + (2*WIDTH)'(1);
    else return v;
  endfunction

  assign a_s         = DataA;
  assign b_s         = DataB;
  assign op_signed   = ~MDOp[0];
  assign accept_md   = (state_q == S_IDLE) && Start && !MDOp[2];
  assign accept_mthi = (state_q == S_IDLE) && Start && (MDOp == 3'b100);
  assign accept_mtlo = (state_q == S_IDLE) && Start && (MDOp == 3'b101);
  assign fix_commit  = (state_q == S_FIX) && !Cancel;

  // Next-state selection; Cancel aborts any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_md) state_d = S_CALC;
      S_CALC: begin
        if (Cancel)                             state_d = S_IDLE;
        else if (count_q == CW'(WIDTH - 1))     state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural state: FSM, iteration counter, Done, HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      vld_p2  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      vld_p2  <= fix_commit;
      if (state_q == S_CALC && !Cancel) count_q <= count_q + CW'(1);
      else                              count_q <= '0;
      if (fix_commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (accept_mthi) hi_q <= DataA;
        if (accept_mtlo) lo_q <= DataA;
      end
    end
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_p1[0] ? b_mag_p1 : {WIDTH{1'b0}})};
    div_trial = acc_p1[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_p1};
    acc_next  = acc_p1;
    if (!is_div_p1)        acc_next = {mul_sum, acc_p1[WIDTH-1:1]};
    else if (div_trial[WIDTH]) acc_next = {acc_p1[2*WIDTH-2:0], 1'b0};
    else                   acc_next = {div_trial[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b1};
  end

  // Operand capture on accept, then iterate the accumulator while calculating.
  always_ff @(posedge clk) begin
    if (accept_md) begin
      acc_p1    <= {{WIDTH{1'b0}}, mag(a_s, op_signed)};
      b_mag_p1  <= mag(b_s, op_signed);
      a_raw_p1  <= DataA;
      is_div_p1 <= MDOp[1];
      neg_q_p1  <= op_signed && (DataA[WIDTH-1] ^ DataB[WIDTH-1]);
      neg_r_p1  <= op_signed && DataA[WIDTH-1];
      div0_p1   <= (DataB == '0);
    end else if (state_q == S_CALC) begin
      acc_p1    <= acc_next;
    end
  end

  // ---- fix-up stage: sign correction and divide-by-zero override ----
  always_comb begin
    prod_fix = cond_neg_wide(acc_p1, neg_q_p1);
    quo_fix  = cond_neg(acc_p1[WIDTH-1:0], neg_q_p1);
    rem_fix  = cond_neg(acc_p1[2*WIDTH-1:WIDTH], neg_r_p1);
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_p1) begin
      if (div0_p1) begin
        res_hi = a_raw_p1;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = vld_p2;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level behavioural model of
// HI/LO/Busy/Done compared every cycle, plus hand-computed literal checks.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] DataA, DataB;
  logic [2:0]  MDOp;
  logic        Start, Cancel;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .DataA(DataA), .DataB(DataB), .MDOp(MDOp),
    .Start(Start), .Cancel(Cancel), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a mul/div using plain 64-bit arithmetic.
  function automatic void model_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo);
    logic signed [31:0] as_, bs_;
    longint sa, sb, q, r;
    logic [63:0] p;
    as_ = a; bs_ = b; sa = as_; sb = bs_;
    hi = '0; lo = '0;
    case (op)
      3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          p = q; lo = p[31:0];
          p = r; hi = p[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  // Behavioural model: a countdown of remaining busy cycles and a pending result.
  always @(posedge clk) begin
    int bl;
    logic [31:0] h, l, ph, pl;
    logic d;
    bl = m_left; h = m_hi; l = m_lo; ph = p_hi; pl = p_lo; d = 1'b0;
    if (reset) begin
      bl = 0; h = '0; l = '0;
    end else if (bl > 0) begin
      if (Cancel) bl = 0;
      else begin
        bl--;
        if (bl == 0) begin h = ph; l = pl; d = 1'b1; end
      end
    end else if (Start) begin
      if (MDOp <= 3'd3) begin
        model_result(MDOp, DataA, DataB, ph, pl);
        bl = 33;
      end else if (MDOp == 3'd4) h = DataA;
      else if (MDOp == 3'd5) l = DataA;
    end
    m_left <= bl; m_hi <= h; m_lo <= l; m_done <= d; p_hi <= ph; p_lo <= pl;
  end

  // Compare DUT against model on every falling edge once out of initial reset.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 32'(Busy), 32'(m_left > 0));
      chk("cyc_done", 32'(Done), 32'(m_done));
      chk("cyc_hi", HI, m_hi);
      chk("cyc_lo", LO, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDOp = op; DataA = a; DataB = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    repeat (36) @(negedge clk);
  endtask

  // Issue an op and measure busy length and Done position over a bounded window.
  task automatic measure(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    int busy_cnt, done_at;
    busy_cnt = 0; done_at = -1;
    issue(op, a, b);
    for (int i = 0; i < 40; i++) begin
      if (Busy) busy_cnt++;
      if (Done && done_at < 0) done_at = i;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({name, "_done_at"}, 32'(done_at), 32'd33);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Cancel = 1'b0; MDOp = 3'd7; DataA = '0; DataB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_done", 32'(Done), 32'h0);

    measure("mult_m3x5", 3'd0, 32'hFFFF_FFFD, 32'd5);
    chk("mult_m3x5_hi", HI, 32'hFFFF_FFFF);
    chk("mult_m3x5_lo", LO, 32'hFFFF_FFF1);

    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi", HI, 32'hFFFF_FFFE);
    chk("multu_max_lo", LO, 32'h0000_0001);

    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mult_m1m1_hi", HI, 32'h0);
    chk("mult_m1m1_lo", LO, 32'h1);

    run(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_hi", HI, 32'hFFFF_FFFF);
    chk("div_m7_2_lo", LO, 32'hFFFF_FFFD);

    run(3'd3, 32'd7, 32'd2);
    chk("divu_7_2_hi", HI, 32'd1);
    chk("divu_7_2_lo", LO, 32'd3);

    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_minneg_hi", HI, 32'h0);
    chk("div_minneg_lo", LO, 32'h8000_0000);

    measure("divu_by0", 3'd3, 32'h1234_5678, 32'h0);
    chk("divu_by0_hi", HI, 32'h1234_5678);
    chk("divu_by0_lo", LO, 32'hFFFF_FFFF);

    // Start while busy is ignored
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    MDOp = 3'd1; DataA = 32'd2; DataB = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (36) @(negedge clk);
    chk("busy_start_hi", HI, 32'd2);
    chk("busy_start_lo", LO, 32'd14);

    // Cancel mid-operation, with a simultaneous MTHI that must be ignored
    issue(3'd0, 32'd5, 32'd5);
    repeat (8) @(negedge clk);
    Cancel = 1'b1; Start = 1'b1; MDOp = 3'd4; DataA = 32'hDEAD_BEEF;
    @(negedge clk);
    Cancel = 1'b0; Start = 1'b0;
    chk("cancel_busy", 32'(Busy), 32'h0);
    chk("cancel_hi", HI, 32'd2);
    chk("cancel_lo", LO, 32'd14);
    repeat (36) @(negedge clk);
    chk("cancel_late_lo", LO, 32'd14);

    // Cancel on the fix-up edge wins over completion
    issue(3'd1, 32'd3, 32'd3);
    repeat (32) @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk);
    Cancel = 1'b0;
    chk("cancel_fix_busy", 32'(Busy), 32'h0);
    chk("cancel_fix_done", 32'(Done), 32'h0);
    chk("cancel_fix_lo", LO, 32'd14);
    repeat (4) @(negedge clk);

    // Reset mid-operation
    issue(3'd1, 32'd3, 32'd3);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_hi", HI, 32'h0);
    chk("midreset_lo", LO, 32'h0);
    chk("midreset_busy", 32'(Busy), 32'h0);
    repeat (40) @(negedge clk);

    // MTHI while idle
    issue(3'd4, 32'hCAFE_F00D, 32'h0);
    chk("mthi_hi", HI, 32'hCAFE_F00D);
    chk("mthi_lo", LO, 32'h0);
    chk("mthi_busy", 32'(Busy), 32'h0);
    chk("mthi_done", 32'(Done), 32'h0);

    // MTLO together with Cancel while idle
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd5; DataA = 32'h1357_9BDF; Cancel = 1'b1;
    @(negedge clk);
    Start = 1'b0; Cancel = 1'b0;
    chk("mtlo_cancel_lo", LO, 32'h1357_9BDF);
    chk("mtlo_cancel_hi", HI, 32'hCAFE_F00D);

    // No-op encoding leaves everything alone
    issue(3'd6, 32'h1111_1111, 32'h2222_2222);
    repeat (2) @(negedge clk);
    chk("noop_busy", 32'(Busy), 32'h0);
    chk("noop_hi", HI, 32'hCAFE_F00D);
    chk("noop_lo", LO, 32'h1357_9BDF);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
